// File: rtl/matrix_stream_tx_if.sv
// matrix_stream_tx_if: AXI-Stream port carrying matrix elements and {K, new_A} framing to the MMM input.
// Latency: none, this is a wire bundle only.
// Backpressure: OUT_TREADY from the slave stalls the master, which holds OUT_TDATA/OUT_TUSER while stalled.
interface matrix_stream_tx_if #(
  parameter int INW   = 12,
  parameter int USR_W = 5
);
  logic [INW-1:0]   OUT_TDATA;
  logic             OUT_TVALID;
  logic [USR_W-1:0] OUT_TUSER;
  logic             OUT_TREADY;

  modport master (
    output OUT_TDATA,
    output OUT_TVALID,
    output OUT_TUSER,
    input  OUT_TREADY
  );

  modport slave (
    input  OUT_TDATA,
    input  OUT_TVALID,
    input  OUT_TUSER,
    output OUT_TREADY
  );
endinterface

// File: rtl/matrix_stream_tx.sv
// matrix_stream_tx: streams preloaded A (M x K) then B (K x N), or B only, in row-major order over AXI-Stream.
// Latency: start accepted at edge t gives OUT_TVALID by edge t+2, then one beat per cycle while OUT_TREADY=1.
// Backpressure: a 2-entry skid absorbs the in-flight RAM read; new reads stop while the skid would overflow.
module matrix_stream_tx #(
  parameter int INW    = 12,
  parameter int M      = 7,
  parameter int N      = 9,
  parameter int MAXK   = 8,
  parameter int K_BITS = $clog2(MAXK + 1),
  parameter int ADDR_W = $clog2(MAXK * ((M > N) ? M : N))
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INW-1:0]     wr_data,
  input  logic               start,
  input  logic [K_BITS-1:0]  start_k,
  input  logic               start_new_a,
  output logic               busy,
  output logic               done,
  output logic               start_err,
  matrix_stream_tx_if.master out
);
  localparam int USR_W   = K_BITS + 1;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int DIM_MN  = (M > N) ? M : N;
  localparam int DIM_MAX = (DIM_MN > MAXK) ? DIM_MN : MAXK;
  localparam int CNT_W   = (DIM_MAX > 1) ? $clog2(DIM_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, DONE} state_t;

  state_t            state;
  logic [K_BITS-1:0] k_q;
  logic              new_a_q;
  logic              first_q;   // next read issued is the first beat of the transfer
  logic              iss_fin;   // every read of the transfer has been issued
  logic [CNT_W-1:0]  row_q;
  logic [CNT_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;

  logic [INW-1:0]    mem_a [DEPTH];
  logic [INW-1:0]    mem_b [DEPTH];
  logic [INW-1:0]    rd_dat;
  logic [USR_W-1:0]  rd_usr;
  logic              rd_pend;

  logic [INW-1:0]    sk_dat [2];
  logic [USR_W-1:0]  sk_usr [2];
  logic [1:0]        sk_cnt;

  logic              start_ok;
  logic              sending;
  logic              pop;
  logic              issue;
  logic              last_col;
  logic              last_row;
  logic              last_beat;
  logic [2:0]        in_flight;
  logic [1:0]        cnt_after_pop;
  logic [CNT_W-1:0]  col_max;
  logic [CNT_W-1:0]  row_max;

  assign start_ok  = start && (start_k != '0) && (start_k <= K_BITS'(MAXK));
  assign sending   = (state == SEND_A) || (state == SEND_B);
  assign pop       = out.OUT_TVALID && out.OUT_TREADY;
  // Skid entries plus the read still in the RAM pipeline; a new read must always find a free slot.
  assign in_flight = {1'b0, sk_cnt} + {2'b00, rd_pend};
  assign issue     = sending && !iss_fin &&
                     ((in_flight < 3'd2) || ((in_flight == 3'd2) && pop));

  // Geometry always comes from the latched K, never from the live start_k.
  assign col_max   = (state == SEND_A) ? (CNT_W'(k_q) - CNT_W'(1)) : CNT_W'(N - 1);
  assign row_max   = (state == SEND_A) ? CNT_W'(M - 1) : (CNT_W'(k_q) - CNT_W'(1));
  assign last_col  = (col_q == col_max);
  assign last_row  = (row_q == row_max);
  assign last_beat = (state == SEND_B) && iss_fin && pop && (sk_cnt == 2'd1) && !rd_pend;

  assign cnt_after_pop  = sk_cnt - {1'b0, pop};
  assign out.OUT_TVALID = (sk_cnt != 2'd0);
  assign out.OUT_TDATA  = sk_dat[0];
  assign out.OUT_TUSER  = sk_usr[0];

  // Host writes land only while idle; the sequencer reads with one cycle of latency.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
    if (issue) rd_dat <= (state == SEND_A) ? mem_a[addr_q] : mem_b[addr_q];
  end

  // Transfer sequencer: accepts start, walks A then B row-major, and reports completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k_q       <= '0;
      new_a_q   <= 1'b0;
      first_q   <= 1'b0;
      iss_fin   <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      rd_pend   <= 1'b0;
      rd_usr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_err <= start && !((state == IDLE) && start_ok);
      rd_pend   <= issue;
      if (issue) begin
        rd_usr  <= first_q ? {k_q, new_a_q} : '0;
        first_q <= 1'b0;
        if (!last_col) begin
          col_q  <= col_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end else begin
          col_q <= '0;
          if (!last_row) begin
            row_q  <= row_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end else begin
            row_q  <= '0;
            addr_q <= '0;
            if (state == SEND_A) state   <= SEND_B;
            else                 iss_fin <= 1'b1;
          end
        end
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            k_q     <= start_k;
            new_a_q <= start_new_a;
            first_q <= 1'b1;
            iss_fin <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            busy    <= 1'b1;
            state   <= start_new_a ? SEND_A : SEND_B;
          end
        end
        SEND_B: begin
          if (last_beat) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: ;
      endcase
    end
  end

  // Output skid: entry 0 drives the port; read data fills the first free slot after any pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        sk_dat[i] <= '0;
        sk_usr[i] <= '0;
      end
    end else begin
      if (pop) begin
        sk_dat[0] <= sk_dat[1];
        sk_usr[0] <= sk_usr[1];
      end
      if (rd_pend) begin
        if (cnt_after_pop == 2'd0) begin
          sk_dat[0] <= rd_dat;
          sk_usr[0] <= rd_usr;
        end else begin
          sk_dat[1] <= rd_dat;
          sk_usr[1] <= rd_usr;
        end
      end
      sk_cnt <= cnt_after_pop + {1'b0, rd_pend};
    end
  end
endmodule

// File: tb/tb_matrix_stream_tx.sv
// tb_matrix_stream_tx: directed bench for matrix_stream_tx with a reference copy of both buffers.
// Latency: each transfer is scored beat by beat against the reference, with stalls checked for stability.
// Backpressure: OUT_TREADY is driven either constantly high or pseudo-randomly.
module tb_matrix_stream_tx;
  localparam int INW    = 12;
  localparam int M      = 7;
  localparam int N      = 9;
  localparam int MAXK   = 8;
  localparam int K_BITS = 4;
  localparam int ADDR_W = 7;
  localparam int USR_W  = K_BITS + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [INW-1:0]    wr_data;
  logic              start;
  logic [K_BITS-1:0] start_k;
  logic              start_new_a;
  logic              busy;
  logic              done;
  logic              start_err;

  int total = 0;
  int bad   = 0;
  int ma [128];
  int mb [128];

  matrix_stream_tx_if #(.INW(INW), .USR_W(USR_W)) sif ();

  matrix_stream_tx #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .start_k     (start_k),
    .start_new_a (start_new_a),
    .busy        (busy),
    .done        (done),
    .start_err   (start_err),
    .out         (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle-time buffer write; the reference copy follows it.
  task automatic wr(input bit sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = ADDR_W'(addr);
    wr_data = INW'(data);
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  task automatic reject(input int k);
    start       = 1'b1;
    start_k     = K_BITS'(k);
    start_new_a = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_err", start_err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_tvalid", sif.OUT_TVALID, 0);
    @(negedge clk);
    chk("rej_err_clear", start_err, 0);
  endtask

  // One transfer: start, score every beat, optionally inject a busy start, a busy write or a reset.
  task automatic run_xfer(input int k, input bit na, input bit rnd,
                          input int inj_start, input int inj_wr, input int abort_beat);
    int exq[$];
    int n, idx, c, first_c, last_c;
    logic [INW-1:0]   pd;
    logic [USR_W-1:0] pu;
    logic [USR_W-1:0] fu;
    bit stall, err_pend, lat_ok;
    exq = {};
    if (na) for (int i = 0; i < M * k; i++) exq.push_back(ma[i]);
    for (int i = 0; i < k * N; i++) exq.push_back(mb[i]);
    n  = exq.size();
    fu = USR_W'((k << 1) | int'(na));
    idx = 0; c = 0; first_c = -1; last_c = -1;
    stall = 1'b0; err_pend = 1'b0; pd = '0; pu = '0;
    start       = 1'b1;
    start_k     = K_BITS'(k);
    start_new_a = na;
    @(negedge clk);
    start = 1'b0;
    chk("busy_set", busy, 1);
    while (idx < n && c < 3000) begin
      wr_en = 1'b0;
      start = 1'b0;
      if (err_pend) begin
        chk("err_while_busy", start_err, 1);
        err_pend = 1'b0;
      end
      if (abort_beat >= 0 && idx == abort_beat) begin
        reset = 1'b1;
        #1;
        chk("abort_tvalid", sif.OUT_TVALID, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        sif.OUT_TREADY = 1'b0;
        @(negedge clk);
        return;
      end
      if (stall) begin
        chk("stall_vld", sif.OUT_TVALID, 1);
        chk("stall_dat", sif.OUT_TDATA, pd);
        chk("stall_usr", sif.OUT_TUSER, pu);
      end
      if (sif.OUT_TVALID && first_c < 0) begin
        first_c = c;
        lat_ok  = (c <= 2);
        chk("first_latency", lat_ok, 1);
      end
      sif.OUT_TREADY = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (c == inj_start) begin
        start = 1'b1; start_k = 4'd3; start_new_a = 1'b1; err_pend = 1'b1;
      end
      if (c == inj_wr) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = ADDR_W'(1); wr_data = 12'h777;
      end
      stall = sif.OUT_TVALID && !sif.OUT_TREADY;
      pd = sif.OUT_TDATA;
      pu = sif.OUT_TUSER;
      if (sif.OUT_TVALID && sif.OUT_TREADY) begin
        chk("beat_dat", sif.OUT_TDATA, exq[idx] & 32'hfff);
        chk("beat_usr", sif.OUT_TUSER, (idx == 0) ? fu : 0);
        idx++;
        last_c = c;
      end
      c++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("beat_count", idx, n);
    chk("done_pulse", done, 1);
    chk("busy_clear", busy, 0);
    chk("tvalid_idle", sif.OUT_TVALID, 0);
    if (!rnd) chk("contiguous", last_c - first_c, n - 1);
    // A start during the done cycle must be refused.
    start = 1'b1; start_k = 4'd2; start_new_a = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_on_done", start_err, 1);
    chk("done_clear", done, 0);
    chk("busy_stays0", busy, 0);
    sif.OUT_TREADY = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_k = '0; start_new_a = 1'b0; sif.OUT_TREADY = 1'b0;
    #12;
    chk("rst_tvalid", sif.OUT_TVALID, 0);
    chk("rst_tdata", sif.OUT_TDATA, 0);
    chk("rst_tuser", sif.OUT_TUSER, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", start_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < M * MAXK; i++) wr(1'b0, i, i + 1);
    for (int i = 0; i < MAXK * N; i++) wr(1'b1, i, 100 + i);

    reject(0);
    reject(9);

    run_xfer(2, 1'b1, 1'b0, -1, -1, -1);   // A then B, full throughput
    run_xfer(3, 1'b0, 1'b0, -1, -1, -1);   // B only
    run_xfer(8, 1'b1, 1'b1, 20, -1, -1);   // largest K, random ready, start while busy
    run_xfer(1, 1'b1, 1'b1, -1, -1, -1);   // K=1 counter wrap

    run_xfer(2, 1'b1, 1'b0, -1, -1, 10);   // reset on beat 10
    run_xfer(3, 1'b0, 1'b0, -1, -1, -1);   // buffers survived the reset

    run_xfer(2, 1'b1, 1'b1, -1, 4, -1);    // write to A[1] while busy is dropped
    wr(1'b0, 0, 12'h555);
    wr(1'b1, 3, 12'h444);
    run_xfer(2, 1'b1, 1'b0, -1, -1, -1);   // new values visible, A[1] unchanged

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
